// File: rtl/pid_seq_pkg.sv
// pid_seq_pkg: sign-magnitude types, FSM states and helpers shared by pid_loop_seq
package pid_seq_pkg;
  localparam int SM_SIGN_BIT = 31;
  typedef logic [31:0] sm32_t;
  typedef enum logic [2:0] {IDLE, SNAP, ERR, START, WAIT, LATCH} seq_state_t;
  function automatic sm32_t sm_norm(sm32_t v);
    return (v[SM_SIGN_BIT-1:0] == '0) ? '0 : v;
  endfunction
  function automatic sm32_t sm_neg(sm32_t v);
    return sm_norm({~v[SM_SIGN_BIT], v[SM_SIGN_BIT-1:0]});
  endfunction
endpackage

// File: rtl/add32.sv
// add32: 32-bit sign-magnitude adder
// ports: a, b operands; sum result (may be -0); ovf magnitude carry-out on like-sign add
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        ovf
);
  logic [31:0] mag_sum;
  logic        same, a_ge;
  assign same    = a[31] == b[31];
  assign mag_sum = {1'b0, a[30:0]} + {1'b0, b[30:0]};
  assign a_ge    = a[30:0] >= b[30:0];
  assign ovf     = same & mag_sum[31];
  assign sum     = same ? {a[31], mag_sum[30:0]} :
                   a_ge ? {a[31], a[30:0] - b[30:0]} : {b[31], b[30:0] - a[30:0]};
endmodule

// File: rtl/pid_loop_seq.sv
// pid_loop_seq: control-loop sequencer that computes errors, starts and collects NUM_AXES pid instances
// ports: clk, rst (sync, active-high); en, loop_tick request a round; setpoint/position per-axis inputs;
//   pid_error/pid_start drive the pids, pid_done/pid_out return from them; axis_out latched outputs;
//   round_done pulse, busy, sticky overrun and timeout_err flags.
// option: define PID_OUT_CLAMP_EN to clamp latched magnitudes to OUT_LIMIT and add the clamp_hit port.
module pid_loop_seq
  import pid_seq_pkg::*;
#(
  parameter int          NUM_AXES    = 3,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] OUT_LIMIT   = 32'h0100_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   loop_tick,
  input  sm32_t [NUM_AXES-1:0]   setpoint,
  input  sm32_t [NUM_AXES-1:0]   position,
  output sm32_t [NUM_AXES-1:0]   pid_error,
  output logic  [NUM_AXES-1:0]   pid_start,
  input  logic  [NUM_AXES-1:0]   pid_done,
  input  sm32_t [NUM_AXES-1:0]   pid_out,
  output sm32_t [NUM_AXES-1:0]   axis_out,
  output logic                   round_done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err
`ifdef PID_OUT_CLAMP_EN
  ,
  output logic  [NUM_AXES-1:0]   clamp_hit
`endif
);
  localparam int IW = NUM_AXES > 1 ? $clog2(NUM_AXES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  seq_state_t            state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [NUM_AXES-1:0]   mask, mask_nxt;
  sm32_t [NUM_AXES-1:0]  snap_sp, snap_pos, latch_val;
  sm32_t                 neg_pos, diff;
  logic                  add_ovf_unused;
  assign neg_pos  = sm_neg(snap_pos[idx]);
  assign mask_nxt = mask | pid_done;
  assign busy     = state != IDLE;
  add32 u_add (.a(snap_sp[idx]), .b(neg_pos), .sum(diff), .ovf(add_ovf_unused));
`ifdef PID_OUT_CLAMP_EN
  logic [NUM_AXES-1:0] over;
  for (genvar k = 0; k < NUM_AXES; k++) begin : g_clamp
    assign over[k]      = {1'b0, pid_out[k][30:0]} > OUT_LIMIT;
    assign latch_val[k] = over[k] ? sm_norm({pid_out[k][31], OUT_LIMIT[30:0]}) : pid_out[k];
  end
  assign clamp_hit = (state == LATCH) ? over & mask : '0;
`else
  logic [31:0] limit_unused;
  assign limit_unused = OUT_LIMIT;
  assign latch_val    = pid_out;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      mask        <= '0;
      snap_sp     <= '0;
      snap_pos    <= '0;
      pid_error   <= '0;
      pid_start   <= '0;
      axis_out    <= '0;
      round_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pid_start  <= '0;
      round_done <= 1'b0;
      if (loop_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (loop_tick && en) state <= SNAP;
        SNAP: begin
          snap_sp  <= setpoint;
          snap_pos <= position;
          idx      <= '0;
          state    <= ERR;
        end
        ERR: begin
          pid_error[idx] <= sm_norm(diff);
          idx            <= idx + 1'b1;
          if (idx == IW'(NUM_AXES - 1)) begin
            state     <= START;
            pid_start <= '1;
            mask      <= '0;
            cnt       <= '0;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          mask <= mask_nxt;
          cnt  <= cnt + 1'b1;
          if (&mask_nxt) begin
            state      <= LATCH;
            round_done <= 1'b1;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state       <= LATCH;
            round_done  <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        LATCH: begin
          for (int k = 0; k < NUM_AXES; k++)
            if (mask[k]) axis_out[k] <= latch_val[k];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_loop_seq.sv
// tb_pid_loop_seq: self-checking bench for pid_loop_seq with an integer-arithmetic reference model
module tb_pid_loop_seq;
  localparam int N = 3;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t [N-1:0]      sp;
    word_t [N-1:0]      pos;
    word_t [N-1:0]      err;
    logic  [N-1:0][7:0] d;
  } vec_t;
  logic clk = 1'b0;
  logic rst, en, loop_tick;
  word_t [N-1:0] setpoint, position, pid_error, pid_out, axis_out;
  logic  [N-1:0] pid_start, pid_done;
  logic round_done, busy, overrun, timeout_err;
`ifdef PID_OUT_CLAMP_EN
  logic [N-1:0] clamp_hit;
`endif
  int    n_tests = 0, n_fail = 0;
  word_t exp_axis [N];
  word_t exp_err [N];
  int    dly [N];
  bit    fin [N];
  bit    exp_ov, exp_to;
  vec_t  vecs [4];
  always #5 clk = ~clk;
  pid_loop_seq #(
    .NUM_AXES(N), .TIMEOUT_CYC(64)
`ifdef PID_OUT_CLAMP_EN
    , .OUT_LIMIT(32'd1000)
`endif
  ) dut (
    .clk(clk), .rst(rst), .en(en), .loop_tick(loop_tick),
    .setpoint(setpoint), .position(position), .pid_error(pid_error),
    .pid_start(pid_start), .pid_done(pid_done), .pid_out(pid_out),
    .axis_out(axis_out), .round_done(round_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
`ifdef PID_OUT_CLAMP_EN
    , .clamp_hit(clamp_hit)
`endif
  );
  function automatic longint sm2i(word_t v);
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction
  function automatic word_t i2sm(longint x);
    return x < 0 ? {1'b1, 31'(-x)} : {1'b0, 31'(x)};
  endfunction
  function automatic word_t model_latch(word_t v);
`ifdef PID_OUT_CLAMP_EN
    if (v[30:0] > 31'd1000) return {v[31], 31'd1000};
`endif
    return v;
  endfunction
  function automatic word_t rand_sm();
    return {1'($urandom), 1'b0, 30'($urandom)};
  endfunction
  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_err();
    for (int k = 0; k < N; k++) exp_err[k] = i2sm(sm2i(setpoint[k]) - sm2i(position[k]));
  endtask
  task automatic run_round(input int mode, output int sc, output int dc);
    int cyc, starts;
    sc = -1;
    dc = -1;
    starts = 0;
    loop_tick = 1'b1;
    step();
    loop_tick = 1'b0;
    cyc = 1;
    while (dc < 0 && cyc < 200) begin
      if (cyc == 2)
        for (int k = 0; k < N; k++) begin
          setpoint[k] = rand_sm();
          position[k] = rand_sm();
        end
      if (pid_start != '0) begin
        starts++;
        check("pid_start", pid_start, {N{1'b1}});
        if (sc < 0) begin
          sc = cyc;
          for (int k = 0; k < N; k++) check($sformatf("pid_error%0d", k), pid_error[k], exp_err[k]);
        end
      end
      for (int k = 0; k < N; k++) pid_done[k] = sc >= 0 && dly[k] >= 0 && cyc >= sc + dly[k];
      loop_tick = mode == 1 && sc >= 0 && cyc == sc + 2;
      if (mode == 2 && sc >= 0 && cyc == sc + 1) en = 1'b0;
      if (round_done) begin
        dc = cyc;
        for (int k = 0; k < N; k++) check($sformatf("axis_out_hold%0d", k), axis_out[k], exp_axis[k]);
`ifdef PID_OUT_CLAMP_EN
        for (int k = 0; k < N; k++)
          check($sformatf("clamp_hit%0d", k), clamp_hit[k], fin[k] && pid_out[k][30:0] > 31'd1000);
`endif
      end else begin
        step();
        cyc++;
      end
    end
    pid_done = '0;
    loop_tick = 1'b0;
    check("start_count", starts, 1);
    if (dc < 0) check("round_done_seen", 0, 1);
  endtask
  task automatic do_round(input int mode);
    int sc, dc, gap;
    bit all;
    all = 1'b1;
    gap = 0;
    for (int k = 0; k < N; k++) begin
      fin[k] = dly[k] >= 1 && dly[k] <= 64;
      all &= fin[k];
      if (dly[k] + 1 > gap) gap = dly[k] + 1;
    end
    if (!all) gap = 65;
    if (!all) exp_to = 1'b1;
    if (mode == 1) exp_ov = 1'b1;
    run_round(mode, sc, dc);
    check("start_latency", sc, 2 + N);
    check("done_latency", dc - sc, gap);
    check("busy_latch", busy, 1);
    step();
    for (int k = 0; k < N; k++) begin
      if (fin[k]) exp_axis[k] = model_latch(pid_out[k]);
      check($sformatf("axis_out%0d", k), axis_out[k], exp_axis[k]);
    end
    check("round_done_pulse", round_done, 0);
    check("busy_after", busy, 0);
    check("overrun", overrun, exp_ov);
    check("timeout_err", timeout_err, exp_to);
  endtask
  initial begin
    vecs[0] = '{sp: {32'd7, 32'd3000, 32'd5000}, pos: {32'd7, 32'd5000, 32'd3000},
                err: {32'h0, 32'h8000_07D0, 32'd2000}, d: {8'd9, 8'd6, 8'd4}};
    vecs[1] = '{sp: {32'h8000_0005, 32'h8000_0000, 32'h8000_0064}, pos: {32'h8000_0005, 32'h0, 32'd50},
                err: {32'h0, 32'h0, 32'h8000_0096}, d: {8'd2, 8'd5, 8'd3}};
    vecs[2] = '{sp: {32'h8000_0032, 32'h8000_0014, 32'd10}, pos: {32'h8000_0014, 32'h8000_0032, 32'h8000_0014},
                err: {32'h8000_001E, 32'h1E, 32'h1E}, d: {8'd1, 8'd1, 8'd1}};
    vecs[3] = '{sp: {32'h3FFF_FFFF, 32'h0, 32'h1234_5678}, pos: {32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h78},
                err: {32'h0, 32'hBFFF_FFFF, 32'h1234_5600}, d: {8'd7, 8'd20, 8'd13}};
    rst = 1'b1; en = 1'b0; loop_tick = 1'b0;
    setpoint = '0; position = '0; pid_done = '0; pid_out = '0;
    exp_ov = 1'b0; exp_to = 1'b0;
    for (int k = 0; k < N; k++) exp_axis[k] = '0;
    step();
    step();
    check("rst_pid_error", pid_error, 0);
    check("rst_axis_out", axis_out, 0);
    check("rst_pid_start", pid_start, 0);
    check("rst_round_done", round_done, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    loop_tick = 1'b1;
    step();
    loop_tick = 1'b0;
    check("en0_busy", busy, 0);
    step();
    check("en0_busy2", busy, 0);
    check("en0_overrun", overrun, 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setpoint = vecs[i].sp;
      position = vecs[i].pos;
      for (int k = 0; k < N; k++) begin
        dly[k] = int'(vecs[i].d[k]);
        exp_err[k] = vecs[i].err[k];
        pid_out[k] = rand_sm();
      end
      do_round(0);
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) begin
        setpoint[k] = rand_sm();
        position[k] = rand_sm();
        pid_out[k] = rand_sm();
        dly[k] = int'($urandom_range(20, 1));
      end
      model_err();
      do_round(0);
    end
    for (int k = 0; k < N; k++) setpoint[k] = rand_sm();
    pid_out = {rand_sm(), 32'd999, 32'h8000_1388};
    dly[0] = 5; dly[1] = 10; dly[2] = -1;
    model_err();
    do_round(0);
    dly[0] = 2; dly[1] = 2; dly[2] = 2;
    pid_out = {rand_sm(), rand_sm(), rand_sm()};
    model_err();
    do_round(2);
    check("en_dropped", en, 0);
    loop_tick = 1'b1;
    step();
    loop_tick = 1'b0;
    check("en_drop_idle", busy, 0);
    check("en_drop_no_overrun", overrun, 0);
    en = 1'b1;
    dly[0] = 3; dly[1] = 4; dly[2] = 5;
    pid_out = {rand_sm(), rand_sm(), rand_sm()};
    model_err();
    do_round(1);
    step();
    check("overrun_no_new_round", busy, 0);
    setpoint = {32'd40, 32'd30, 32'd1234};
    position = {32'd1, 32'd2, 32'd4};
    model_err();
    loop_tick = 1'b1;
    step();
    loop_tick = 1'b0;
    step();
    step();
    check("mid_busy", busy, 1);
    check("mid_err0", pid_error[0], exp_err[0]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) exp_axis[k] = '0;
    exp_ov = 1'b0;
    exp_to = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pid_error", pid_error, 0);
    check("mid_rst_axis_out", axis_out, 0);
    check("mid_rst_flags", {overrun, timeout_err}, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (round_done || pid_start != '0 || busy) seen++;
        step();
      end
      check("mid_rst_quiet", seen, 0);
    end
    dly[0] = 6; dly[1] = 1; dly[2] = 3;
    pid_out = {rand_sm(), rand_sm(), rand_sm()};
    model_err();
    do_round(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pid_loop_seq.md
Name: pid_loop_seq

Overview:
- Control-loop sequencer for NUM_AXES independent pid instances (roll/pitch/yaw).
- On each loop tick it:
  - snapshots setpoint and position per axis;
  - computes sign-magnitude error = setpoint - position through one shared add32;
  - drives the per-axis pid error inputs and pulses start_calc to all instances;
  - waits for every done, with a timeout;
  - latches the PID outputs and signals round completion.
- It replaces the tick/start/done/error bookkeeping currently done ad hoc around pid.

Parameters:
- NUM_AXES, 3, number of pid instances sequenced.
- TIMEOUT_CYC, 64, max cycles in WAIT before abort.
- OUT_LIMIT, 32'h0100_0000, magnitude clamp (used only with PID_OUT_CLAMP_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sequencer enable, sampled only in IDLE.
- loop_tick  in  1  one-cycle request to run a control round.
- setpoint  in  [NUM_AXES][32]  per-axis setpoint, sign-magnitude.
- position  in  [NUM_AXES][32]  per-axis measured position, sign-magnitude.
- pid_error  out  [NUM_AXES][32]  error to each pid, sign-magnitude.
- pid_start  out  [NUM_AXES]  start_calc to each pid.
- pid_done  in  [NUM_AXES]  done from each pid.
- pid_out  in  [NUM_AXES][32]  PID_out from each pid.
- axis_out  out  [NUM_AXES][32]  latched controller output per axis.
- round_done  out  1  one-cycle pulse when a round ends.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: loop_tick arrived while busy.
- timeout_err  out  1  sticky: a round hit TIMEOUT_CYC.

Behaviour:
- Reset: takes effect on the clk edge where rst=1.
  - State returns to IDLE; axis index, timeout counter and done mask are cleared.
  - All outputs go to 0, including pid_error, axis_out and both sticky flags.
  - Reset mid-round aborts the round with no round_done pulse.
- Number format: 32-bit sign-magnitude, bit31 = sign.
  - Negation = invert bit31.
  - Any -0 result is normalised to +0 before it is driven.
- States: IDLE -> SNAP -> ERR -> START -> WAIT -> LATCH -> IDLE.
- IDLE: on loop_tick && en, go to SNAP. A tick with en=0 is ignored, with no overrun.
- SNAP (1 cycle): register setpoint/position for all axes. Later input changes do not affect the round.
- ERR (NUM_AXES cycles):
  - Axis k is processed in cycle k.
  - Shared add32 computes snap_sp[k] + {~snap_pos[k][31], snap_pos[k][30:0]}.
  - The result is registered into pid_error[k].
  - The add32 overflow output is ignored.
- START (1 cycle): pid_start = all ones. The done mask is cleared on entry.
- WAIT:
  - pid_done bits OR into the sticky done mask.
  - When the mask is all ones, go to LATCH.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT_CYC first, set timeout_err and go to LATCH.
  - pid_done outside WAIT is ignored.
  - A done bit that is already set and re-asserts has no effect.
- LATCH (1 cycle):
  - axis_out[k] <= pid_out[k] for axes whose mask bit is set. Unfinished axes hold their previous value.
  - round_done = 1 in this cycle; axis_out is visible the following cycle.
- Latency: tick sampled at cycle T gives:
  - SNAP at T+1;
  - ERR at T+2 .. T+1+N;
  - pid_start at T+2+N;
  - round_done at least 2 cycles after START.
- loop_tick while busy: ignored, overrun set; the current round is unaffected.
- Dropping en mid-round does not abort the round; it only takes effect at the next IDLE.

Optional Feature:
- Macro: PID_OUT_CLAMP_EN.
- Defined: in LATCH, any axis whose pid_out magnitude > OUT_LIMIT latches {sign, OUT_LIMIT[30:0]}, and an extra output port clamp_hit [NUM_AXES] pulses in that cycle.
- Undefined: pid_out is passed through unmodified and the clamp_hit port does not exist.

Decomposition:
- Package pid_seq_pkg contains:
  - typedef sm32_t, a packed 32-bit sign-magnitude value;
  - enum seq_state_t {IDLE, SNAP, ERR, START, WAIT, LATCH};
  - function sm_neg (invert sign, normalise -0);
  - function sm_norm;
  - constant SM_SIGN_BIT = 31.
- Sub-module: a single instance of the existing add32, input-muxed by the axis index. No new sub-module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, busy=0. A tick with en=0 -> busy stays 0 and overrun stays 0.
- Error math, axes 0/1/2:
  - sp=5000, pos=3000 -> pid_error +2000.
  - sp=3000, pos=5000 -> sign=1, mag=2000.
  - sp=pos=7 -> exactly 32'h0, never 32'h8000_0007 or -0.
- Nominal round with N=3:
  - Tick at T -> pid_start=3'b111 only at T+5.
  - Model pids raise done at +4, +6, +9 cycles.
  - round_done one cycle after the last done; axis_out equals each model's pid_out.
- Timeout: axis 2 never asserts done, TIMEOUT_CYC=64.
  - round_done after 64 WAIT cycles; timeout_err=1.
  - axis_out[2] holds its old value; axes 0 and 1 update.
- Overrun and mid-round reset:
  - Second tick during WAIT -> overrun=1 and the round still completes normally.
  - rst during ERR -> state IDLE, no round_done, pid_error=0.
- With PID_OUT_CLAMP_EN, OUT_LIMIT=1000:
  - pid_out=-5000 -> axis_out sign=1, mag=1000, clamp_hit[k]=1.
  - pid_out=+999 -> passed through, clamp_hit[k]=0.
